fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the CPU's decode/execute datapath. Holds the fetch PC, issues in-order word requests to instruction memory under a credit scheme, buffers returned instructions with their PC in a small prefetch FIFO, and presents them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO, retarget the PC and discard responses still in flight.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2; also the cap on inflight plus buffered instructions.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state returns to reset values while low.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in 32: new fetch address.
- `mem_req_valid` out 1: request to instruction memory.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_addr` out 32: word address (bits [1:0] = 0).
- `mem_resp_valid` in 1: response data valid; in request order, no backpressure, latency ≥1 cycle.
- `mem_resp_data` in 32: instruction word.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: decode consumes head.
- `out_instr` out 32: head instruction.
- `out_pc` out 32: head instruction address.
- `out_pc_plus4` out 32: `out_pc + 4`, mod 2^32.
- `fetch_misalign` out 1: sticky misaligned-redirect flag (only with `FETCH_ALIGN_CHECK_EN`; else tied 0).

## Operation
- State: `fetch_pc`, FIFO (instr + pc per entry, `$clog2(DEPTH)+1`-bit count), `inflight` (issued, not returned), `stale` (inflight to discard), `req_pc` queue tracking PCs of inflight requests (depth `DEPTH`).
- Issue: `mem_req_valid = !redirect_valid && !halted && (count + inflight < DEPTH)`; `mem_req_addr = fetch_pc`. On `mem_req_valid && mem_req_ready`: `fetch_pc += 4` (wraps 32'hFFFF_FFFC → 0), `inflight++`, push `fetch_pc` onto `req_pc` queue.
- Response: every `mem_resp_valid` retires one inflight (`inflight--`, pop `req_pc`). If `stale > 0`: discard, `stale--`. Else push {data, popped pc} into FIFO. Credit rule guarantees the FIFO never overflows; no response ready exists.
- Output: `out_valid = (count != 0)`; pop on `out_valid && out_ready`.
- Simultaneous push and pop: count unchanged, both occur.
- Redirect (priority over everything): FIFO flushed to empty (a same-cycle pop is harmless), `fetch_pc <= redirect_pc`, `stale <=` inflight count after this cycle's retirement (all remaining requests are stale), a response arriving in the redirect cycle is discarded, no request issued in the redirect cycle.
- Back-to-back redirects: each re-snapshots `stale` from current inflight; last target wins.
- Reset mid-operation: everything cleared; any later responses for pre-reset requests are the memory's responsibility (memory is reset together).

## Timing
- Reset values: `fetch_pc = RESET_PC`, count 0, `inflight 0`, `stale 0`, `fetch_misalign 0`; hence `out_valid 0`, `mem_req_valid 1` once reset released (no redirect).
- `mem_req_*`, `out_*` are combinational from registered state (plus `redirect_valid` gating on `mem_req_valid`); no input-to-output path on `out_*`.
- Latency: response in cycle N → `out_valid` in cycle N+1.
- Redirect in cycle N: `out_valid 0` in N+1; first request to `redirect_pc` issued in N+1.
- Steady state with 1-cycle memory and `out_ready` high: one instruction per cycle.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0] != 0` sets `fetch_misalign` (sticky until reset or next aligned redirect) and sets `halted`, suppressing requests; aligned redirect clears both.
- Undefined: `redirect_pc[1:0]` forced to 0, `fetch_misalign` tied 0, `halted` constant 0.

## Test plan
- Reset release, 1-cycle memory, `out_ready` 1 → `out_pc` sequence 0x0, 0x4, 0x8, one per cycle, `out_pc_plus4` = pc+4.
- `out_ready` 0, DEPTH=4 → exactly 4 requests issued, `mem_req_valid` then 0; `out_ready` 1 → 4 entries drain in order, requests resume.
- 3-cycle memory latency, 3 inflight, redirect to 0x100 → all 3 responses discarded, next `out_pc` = 0x100, no gap instruction delivered.
- Redirect coincident with response and with out pop → response discarded, FIFO empty next cycle, fetch from target.
- `fetch_pc` = 0xFFFF_FFFC → next request address 0x0, `out_pc_plus4` = 0x0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `fetch_misalign` 1, no requests; redirect to 0x200 → flag 0, fetch 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with credit-limited memory requests,
// an in-order prefetch FIFO carrying {instr, pc}, and redirect flush that
// discards responses still in flight.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirects set a
// sticky fetch_misalign flag and halt fetching until an aligned redirect).
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   instrMem_q [DEPTH];
    logic [31:0]   pcMem_q    [DEPTH];
    logic [31:0]   reqPcMem_q [DEPTH];

    logic [31:0]   fetchPc_q,   fetchPc_d;
    logic [AW-1:0] wrPtr_q,     wrPtr_d;
    logic [AW-1:0] rdPtr_q,     rdPtr_d;
    logic [AW-1:0] reqWrPtr_q,  reqWrPtr_d;
    logic [AW-1:0] reqRdPtr_q,  reqRdPtr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [CW-1:0] inflight_q,  inflight_d;
    logic [CW-1:0] stale_q,     stale_d;

    logic          halted;
    logic [CW:0]   creditsUsed;
    logic          reqFire;
    logic          fifoPush;
    logic          fifoPop;
    logic [31:0]   respPc;
    logic [31:0]   alignedTarget;

    // Low address bits are dropped so every request stays word aligned.
    assign alignedTarget = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    // Sticky misalign flag: each redirect re-evaluates it, and while set the
    // unit stops issuing requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign halted         = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    assign halted         = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    assign creditsUsed   = {1'b0, count_q} + {1'b0, inflight_q};
    assign mem_req_valid = !redirect_valid && !halted && (creditsUsed < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetchPc_q;
    assign reqFire       = mem_req_valid && mem_req_ready;

    assign respPc        = reqPcMem_q[reqRdPtr_q];
    assign fifoPush      = mem_resp_valid && !redirect_valid && (stale_q == '0);

    assign out_valid     = (count_q != '0);
    assign out_instr     = instrMem_q[rdPtr_q];
    assign out_pc        = pcMem_q[rdPtr_q];
    assign out_pc_plus4  = pcMem_q[rdPtr_q] + 32'd4;
    assign fifoPop       = out_valid && out_ready;

    // Next-state for PC, FIFO pointers/count and the inflight/stale counters;
    // a redirect flushes the FIFO and marks every remaining request stale.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        stale_d    = stale_q;
        inflight_d = inflight_q + CW'(reqFire) - CW'(mem_resp_valid);
        reqWrPtr_d = reqWrPtr_q + AW'(reqFire);
        reqRdPtr_d = reqRdPtr_q + AW'(mem_resp_valid);

        if (redirect_valid) begin
            fetchPc_d = alignedTarget;
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            stale_d   = inflight_q - CW'(mem_resp_valid);
        end else begin
            if (reqFire) begin
                fetchPc_d = fetchPc_q + 32'd4;
            end
            wrPtr_d = wrPtr_q + AW'(fifoPush);
            rdPtr_d = rdPtr_q + AW'(fifoPop);
            count_d = count_q + CW'(fifoPush) - CW'(fifoPop);
            if (mem_resp_valid && (stale_q != '0)) begin
                stale_d = stale_q - CW'(1);
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc_q  <= RESET_PC;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            reqWrPtr_q <= '0;
            reqRdPtr_q <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            stale_q    <= '0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            reqWrPtr_q <= reqWrPtr_d;
            reqRdPtr_q <= reqRdPtr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    // Data storage needs no reset: entries are only read once count/inflight
    // say they were written.
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            instrMem_q[wrPtr_q] <= mem_resp_data;
            pcMem_q[wrPtr_q]    <= respPc;
        end
        if (reqFire) begin
            reqPcMem_q[reqWrPtr_q] <= fetchPc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A memory model answers
// requests in order after a configurable latency; expected {pc, instr} are
// queued when requests issue and compared when decode pops the FIFO.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fetch_misalign;

    int          vectors;
    int          miscompares;
    int          cycle;
    int          lat;
    int          lastDue;
    int          fires;
    int          pops;
    logic [31:0] tbPc;
    logic        tbHalted;
    logic [31:0] memQ[$];
    int          memDue[$];
    logic [31:0] sbq[$];

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        out_ready      = 1'b0;
        mem_req_ready  = 1'b1;
        memQ.delete();
        memDue.delete();
        sbq.delete();
        tbPc     = 32'h0;
        tbHalted = 1'b0;
        lastDue  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // One clock of stimulus; called just after a falling edge.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic ordy, input logic mrdy);
        int due;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        mem_req_ready  = mrdy;
        if (memQ.size() > 0 && memDue[0] <= cycle) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = instrOf(memQ.pop_front());
            void'(memDue.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
        end
        #1;
        if (out_valid && out_ready) begin
            pops++;
            if (sbq.size() == 0) begin
                checkOutput("unexpected_out_pc", out_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] expPc;
                expPc = sbq.pop_front();
                checkOutput("out_pc", out_pc, expPc);
                checkOutput("out_instr", out_instr, instrOf(expPc));
                checkOutput("out_pc_plus4", out_pc_plus4, expPc + 32'd4);
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            fires++;
            checkOutput("req_addr", mem_req_addr, tbPc);
            due = cycle + lat;
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memQ.push_back(mem_req_addr);
            memDue.push_back(due);
            sbq.push_back(tbPc);
            tbPc = tbPc + 32'd4;
        end
        if (redir) begin
            sbq.delete();
            tbPc = rpc & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
            tbHalted = (rpc[1:0] != 2'b00);
`else
            tbHalted = 1'b0;
`endif
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
    endtask

    // Test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        lat         = 1;
        reset       = 1'b0;

        // Reset state.
        doReset();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("rst_req_addr", mem_req_addr, 32'h0);
        checkOutput("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

        // Streaming with 1-cycle memory: one instruction per cycle.
        pops = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("stream_pops", pops, 32'd8);

        // Backpressure: exactly DEPTH requests, then drain and resume.
        doReset();
        fires = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("credit_fires", fires, 32'd4);
        checkOutput("credit_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("credit_out_valid", {31'b0, out_valid}, 32'd1);
        fires = 0;
        pops  = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("drain_resumed", {31'b0, fires > 0}, 32'd1);
        checkOutput("drain_pops_min", {31'b0, pops >= 4}, 32'd1);

        // 3-cycle memory, redirect while 3 requests are inflight.
        doReset();
        lat = 3;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        checkOutput("redir3_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("redir3_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("redir3_req_addr", mem_req_addr, 32'h0000_0100);
        pops = 0;
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("redir3_pops_min", {31'b0, pops >= 3}, 32'd1);

        // Redirect coinciding with a response and a pop in steady state.
        doReset();
        lat = 1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("coin_out_valid_pre", {31'b0, out_valid}, 32'd1);
        applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        checkOutput("coin_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("coin_req_addr", mem_req_addr, 32'h0000_0300);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Address wrap at the top of the 32-bit space.
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        checkOutput("wrap_addr0", mem_req_addr, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap_addr1", mem_req_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap_addr2", mem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Misaligned redirect handling.
        applyStimulus(1'b1, 32'h0000_0102, 1'b1, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("mis_flag_set", {31'b0, fetch_misalign}, 32'd1);
        checkOutput("mis_req_valid", {31'b0, mem_req_valid}, 32'd0);
        fires = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("mis_no_fires", fires, 32'd0);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        checkOutput("mis_flag_clr", {31'b0, fetch_misalign}, 32'd0);
        checkOutput("mis_req_addr", mem_req_addr, 32'h0000_0200);
`else
        checkOutput("mis_flag_tied", {31'b0, fetch_misalign}, 32'd0);
        checkOutput("mis_req_addr", mem_req_addr, 32'h0000_0100);
`endif
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic: variable latency, backpressure and redirects.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [31:0] t;
            lat = $urandom_range(1, 3);
            r   = ($urandom_range(0, 19) == 0);
            t   = $urandom & 32'hFFFF_FFFC;
            applyStimulus(r, t, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        lat = 1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("final_sb_empty", sbq.size(), 32'd0);
        checkOutput("final_out_valid", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
